// File: rtl/seg7_capture_decoder_if.sv
// Display-bus capture interface: sampled segment pattern in, decoded digit events out.
// The decimal-point pair exists only when SEG7_CAPTURE_DP_EN is defined.
interface seg7_capture_decoder_if;
    logic [6:0] iSEG;
    logic       iREADY;
    logic [3:0] oDIG;
    logic       oVALID;
    logic       oERR;
    logic       oBLANK;
    logic       oOVF;
`ifdef SEG7_CAPTURE_DP_EN
    logic       iDP;
    logic       oDP;

    modport master (output iSEG, iREADY, iDP,
                    input  oDIG, oVALID, oERR, oBLANK, oOVF, oDP);
    modport slave  (input  iSEG, iREADY, iDP,
                    output oDIG, oVALID, oERR, oBLANK, oOVF, oDP);
`else
    modport master (output iSEG, iREADY,
                    input  oDIG, oVALID, oERR, oBLANK, oOVF);
    modport slave  (input  iSEG, iREADY,
                    output oDIG, oVALID, oERR, oBLANK, oOVF);
`endif
endinterface

// File: rtl/seg7_capture_decoder.sv
// Captures an active-low 7-segment pattern, qualifies it as stable and decodes it to a hex digit
// event on a valid/ready handshake. Define SEG7_CAPTURE_DP_EN to also track the decimal point.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic                   iCLK,
    input logic                   iRST_N,
    seg7_capture_decoder_if.slave bus
);
`ifdef SEG7_CAPTURE_DP_EN
    localparam int PAT_W = 8;
`else
    localparam int PAT_W = 7;
`endif
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic {TRACK, PRESENT} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] seg_q;
    logic [PAT_W-1:0] seg_d;
    logic [PAT_W-1:0] qual_pat;
    logic [PAT_W-1:0] last_pat;
    logic             seg_q_vld;
    logic             fresh;
    logic             last_vld;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             fresh_next;
    logic             changed;
    logic             qual_blank;
    logic             dup;
    logic             event_ok;
    logic [4:0]       dec;
    logic [3:0]       dig;
    logic             err;
    logic             valid;
    logic             blank;
    logic             ovf;

`ifdef SEG7_CAPTURE_DP_EN
    logic             dp;
    assign pat_in    = {bus.iDP, bus.iSEG};
    assign bus.oDP   = dp;
`else
    assign pat_in    = bus.iSEG;
`endif

    // Returns {err, digit}; anything outside the glyph table is an error with digit 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0011000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // A zero count means nothing has been compared yet, so the first real sample restarts at 1.
    assign changed = (cnt == '0) || (seg_q != seg_d);

    always_comb begin
        cnt_next   = cnt;
        fresh_next = 1'b0;
        if (seg_q_vld) begin
            if (changed) begin
                cnt_next   = ONE;
                fresh_next = (STABLE == ONE);
            end else if (cnt != STABLE) begin
                cnt_next   = cnt + ONE;
                fresh_next = ((cnt + ONE) == STABLE);
            end
        end
    end

    assign qual_blank = (qual_pat[6:0] == 7'h7F);
    assign dup        = last_vld && (qual_pat == last_pat);
    assign event_ok   = fresh && !qual_blank && !dup;
    assign dec        = decode(qual_pat[6:0]);

    // Qualification is registered one cycle ahead of the handshake FSM that consumes it.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= TRACK;
            seg_q     <= '1;
            seg_d     <= '1;
            qual_pat  <= '1;
            last_pat  <= '1;
            seg_q_vld <= 1'b0;
            fresh     <= 1'b0;
            last_vld  <= 1'b0;
            cnt       <= '0;
            dig       <= 4'h0;
            err       <= 1'b0;
            valid     <= 1'b0;
            blank     <= 1'b0;
            ovf       <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
            dp        <= 1'b0;
`endif
        end else begin
            seg_q     <= pat_in;
            seg_q_vld <= 1'b1;
            seg_d     <= seg_q;
            cnt       <= cnt_next;
            fresh     <= fresh_next;
            if (fresh_next) begin
                qual_pat <= seg_q;
            end

            if (fresh) begin
                if (qual_blank) begin
                    blank    <= 1'b1;
                    last_vld <= 1'b0;
                end else begin
                    blank <= 1'b0;
                    if (!dup) begin
                        last_pat <= qual_pat;
                        last_vld <= 1'b1;
                    end
                end
            end

            case (state)
                TRACK: begin
                    if (event_ok) begin
                        dig   <= dec[3:0];
                        err   <= dec[4];
`ifdef SEG7_CAPTURE_DP_EN
                        dp    <= ~qual_pat[7];
`endif
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.iREADY) begin
                        if (event_ok) begin
                            dig <= dec[3:0];
                            err <= dec[4];
`ifdef SEG7_CAPTURE_DP_EN
                            dp  <= ~qual_pat[7];
`endif
                        end else begin
                            valid <= 1'b0;
                            state <= TRACK;
                        end
                    end else if (event_ok) begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= TRACK;
                end
            endcase
        end
    end

    assign bus.oDIG   = dig;
    assign bus.oERR   = err;
    assign bus.oVALID = valid;
    assign bus.oBLANK = blank;
    assign bus.oOVF   = ovf;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: timing, decode, duplicate/blank rules, backpressure, reset.
// Runs the decimal-point scenario as well when SEG7_CAPTURE_DP_EN is defined.
module tb_seg7_capture_decoder;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_3     = 7'b0110000;
    localparam logic [6:0] P_4     = 7'b0011001;
    localparam logic [6:0] P_5     = 7'b0010010;
    localparam logic [6:0] P_6     = 7'b0000010;
    localparam logic [6:0] P_8     = 7'b0000000;
    localparam logic [6:0] P_A     = 7'b0001000;
    localparam logic [6:0] P_BAD   = 7'b1010101;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   ev_count = 0;
    logic [3:0]  ev_dig = 4'h0;
    logic        ev_err = 1'b0;
    logic [15:0] ev_mask = 16'h0;

    seg7_capture_decoder_if bus ();

    seg7_capture_decoder #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Handshake monitor: records every accepted event.
    always @(negedge clk) begin
        if (bus.oVALID && bus.iREADY) begin
            ev_count++;
            ev_dig = bus.oDIG;
            ev_err = bus.oERR;
            ev_mask[bus.oDIG] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_events();
        ev_count = 0;
        ev_mask  = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.iSEG = P_BLANK;
        bus.iREADY = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
        bus.iDP = 1'b1;
`endif
        tick_n(2);
        total++; if (bus.oDIG !== 4'h0) begin bad++; $display("[TB] FAIL reset_dig got=%0h exp=0", bus.oDIG); end
        total++; if (bus.oVALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.oVALID); end
        total++; if (bus.oERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b exp=0", bus.oERR); end
        total++; if (bus.oBLANK !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank got=%0b exp=0", bus.oBLANK); end
        total++; if (bus.oOVF !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%0b exp=0", bus.oOVF); end
    endtask

    task automatic test_basic();
        clear_events();
        rst_n = 1'b1;
        bus.iSEG = P_2;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (bus.oVALID !== (e == 6)) begin
                bad++; $display("[TB] FAIL basic_valid edge=%0d got=%0b exp=%0b", e, bus.oVALID, (e == 6));
            end
            if (e == 6) begin
                total++; if (bus.oDIG !== 4'h2) begin bad++; $display("[TB] FAIL basic_dig got=%0h exp=2", bus.oDIG); end
                total++; if (bus.oERR !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got=%0b exp=0", bus.oERR); end
            end
        end
        tick_n(10);
        total++; if (ev_count !== 1) begin bad++; $display("[TB] FAIL basic_count got=%0d exp=1", ev_count); end
    endtask

    task automatic test_unstable();
        clear_events();
        bus.iSEG = P_3;
        tick_n(3);
        bus.iSEG = P_4;
        tick_n(10);
        total++; if (ev_count !== 1) begin bad++; $display("[TB] FAIL unstable_count got=%0d exp=1", ev_count); end
        total++; if (ev_dig !== 4'h4) begin bad++; $display("[TB] FAIL unstable_dig got=%0h exp=4", ev_dig); end
        total++; if (ev_mask !== 16'h0010) begin bad++; $display("[TB] FAIL unstable_mask got=%04h exp=0010", ev_mask); end
    endtask

    task automatic test_invalid();
        clear_events();
        bus.iSEG = P_BAD;
        tick_n(10);
        total++; if (ev_count !== 1) begin bad++; $display("[TB] FAIL invalid_count got=%0d exp=1", ev_count); end
        total++; if (ev_err !== 1'b1) begin bad++; $display("[TB] FAIL invalid_err got=%0b exp=1", ev_err); end
        total++; if (ev_dig !== 4'h0) begin bad++; $display("[TB] FAIL invalid_dig got=%0h exp=0", ev_dig); end
    endtask

    task automatic test_backpressure();
        clear_events();
        bus.iREADY = 1'b0;
        bus.iSEG = P_5;
        tick_n(8);
        total++; if (bus.oVALID !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid1 got=%0b exp=1", bus.oVALID); end
        total++; if (bus.oDIG !== 4'h5) begin bad++; $display("[TB] FAIL bp_dig1 got=%0h exp=5", bus.oDIG); end
        total++; if (bus.oOVF !== 1'b0) begin bad++; $display("[TB] FAIL bp_ovf1 got=%0b exp=0", bus.oOVF); end
        bus.iSEG = P_6;
        tick_n(8);
        total++; if (bus.oVALID !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid2 got=%0b exp=1", bus.oVALID); end
        total++; if (bus.oDIG !== 4'h5) begin bad++; $display("[TB] FAIL bp_dig2 got=%0h exp=5", bus.oDIG); end
        total++; if (bus.oOVF !== 1'b1) begin bad++; $display("[TB] FAIL bp_ovf2 got=%0b exp=1", bus.oOVF); end
        total++; if (ev_count !== 0) begin bad++; $display("[TB] FAIL bp_noaccept got=%0d exp=0", ev_count); end
        bus.iREADY = 1'b1;
        tick();
        bus.iREADY = 1'b0;
        total++; if (bus.oVALID !== 1'b0) begin bad++; $display("[TB] FAIL bp_drop got=%0b exp=0", bus.oVALID); end
        total++; if (ev_count !== 1) begin bad++; $display("[TB] FAIL bp_accept got=%0d exp=1", ev_count); end
        total++; if (ev_dig !== 4'h5) begin bad++; $display("[TB] FAIL bp_accept_dig got=%0h exp=5", ev_dig); end
        tick_n(6);
        total++; if (bus.oVALID !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_reemit got=%0b exp=0", bus.oVALID); end
        bus.iREADY = 1'b1;
    endtask

    task automatic test_blank_reemit();
        clear_events();
        bus.iSEG = P_8;
        tick_n(6);
        total++; if (bus.oBLANK !== 1'b0) begin bad++; $display("[TB] FAIL blank_pre got=%0b exp=0", bus.oBLANK); end
        bus.iSEG = P_BLANK;
        tick_n(6);
        total++; if (bus.oBLANK !== 1'b1) begin bad++; $display("[TB] FAIL blank_set got=%0b exp=1", bus.oBLANK); end
        total++; if (ev_count !== 1) begin bad++; $display("[TB] FAIL blank_first got=%0d exp=1", ev_count); end
        bus.iSEG = P_8;
        tick_n(6);
        total++; if (bus.oBLANK !== 1'b0) begin bad++; $display("[TB] FAIL blank_clear got=%0b exp=0", bus.oBLANK); end
        total++; if (bus.oVALID !== 1'b1) begin bad++; $display("[TB] FAIL blank_reemit got=%0b exp=1", bus.oVALID); end
        tick_n(10);
        total++; if (ev_count !== 2) begin bad++; $display("[TB] FAIL blank_count got=%0d exp=2", ev_count); end
        total++; if (ev_mask !== 16'h0100) begin bad++; $display("[TB] FAIL blank_mask got=%04h exp=0100", ev_mask); end
    endtask

    task automatic test_reset_midway();
        bus.iSEG = P_A;
        tick_n(4);
        rst_n = 1'b0;
        tick();
        total++; if (bus.oOVF !== 1'b0) begin bad++; $display("[TB] FAIL mid_ovf got=%0b exp=0", bus.oOVF); end
        total++; if (bus.oVALID !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0b exp=0", bus.oVALID); end
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            total++;
            if (bus.oVALID !== (t == 6)) begin
                bad++; $display("[TB] FAIL mid_timing t=%0d got=%0b exp=%0b", t, bus.oVALID, (t == 6));
            end
            if (t == 6) begin
                total++; if (bus.oDIG !== 4'hA) begin bad++; $display("[TB] FAIL mid_dig got=%0h exp=a", bus.oDIG); end
            end
        end
    endtask

`ifdef SEG7_CAPTURE_DP_EN
    task automatic test_dp();
        total++; if (bus.oDP !== 1'b0) begin bad++; $display("[TB] FAIL dp_off got=%0b exp=0", bus.oDP); end
        bus.iDP = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            total++;
            if (bus.oVALID !== (t == 6)) begin
                bad++; $display("[TB] FAIL dp_valid t=%0d got=%0b exp=%0b", t, bus.oVALID, (t == 6));
            end
            if (t == 6) begin
                total++; if (bus.oDIG !== 4'hA) begin bad++; $display("[TB] FAIL dp_dig got=%0h exp=a", bus.oDIG); end
                total++; if (bus.oDP !== 1'b1) begin bad++; $display("[TB] FAIL dp_on got=%0b exp=1", bus.oDP); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_unstable();
        test_invalid();
        test_backpressure();
        test_blank_reemit();
        test_reset_midway();
`ifdef SEG7_CAPTURE_DP_EN
        test_dp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
Inverse of the hex-to-7-segment encoder. Samples an active-low 7-segment drive pattern, qualifies it as stable over a programmable number of cycles, and decodes it back to a 4-bit hex digit. The digit is presented to a consumer over a valid/ready handshake. Sits on the display bus as a self-check monitor and loopback capture for ADC/motor readout verification.

Parameters:
STABLE_CYCLES, 4, consecutive cycles a sampled pattern must hold before it qualifies (legal range 1..255)
CNT_W, 8, stability counter width (must satisfy 2^CNT_W > STABLE_CYCLES)

Ports:
iCLK  input  1  single clock, all logic on rising edge
iRST_N  input  1  synchronous, active-low reset
iSEG  input  7  active-low segment pattern; bit0=a ... bit6=g
iREADY  input  1  consumer accepts the current event
oDIG  output  4  decoded hex digit
oVALID  output  1  event valid; held until accepted
oERR  output  1  event pattern is not a legal hex glyph
oBLANK  output  1  last qualified pattern was all-off (7'b1111111)
oOVF  output  1  sticky; an event was dropped under backpressure

Behaviour:
- Reset: synchronous, active-low. Sampled on iCLK when iRST_N=0. Outputs oDIG=0, oVALID=0, oERR=0, oBLANK=0, oOVF=0. Stability counter=0; last-emitted register marked empty.
- Reset mid-operation: discards partial qualification and any pending event. The next pattern needs a full STABLE_CYCLES to qualify.
- Input stage: iSEG is registered to seg_q every cycle.
- Stability counter:
  - Loads 1 when seg_q differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Qualify event: occurs on the cycle the counter first reaches STABLE_CYCLES.
- Latency: if iSEG is constant from edge k, the qualify event falls at edge k+STABLE_CYCLES and outputs update at edge k+STABLE_CYCLES+1.
- Decode table (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Invalid pattern (any other non-blank pattern): event carries oDIG=0 and oERR=1.
- Blank pattern:
  - Produces no event.
  - Sets oBLANK=1 and clears the last-emitted register, so the same digit re-emits after a blank.
  - Any non-blank qualification clears oBLANK.
- Duplicate suppression: a qualified pattern equal to the last-emitted pattern produces no event.
- FSM states:
  - TRACK: oVALID=0. On a qualify event, load oDIG/oERR, update last-emitted, go to PRESENT.
  - PRESENT: oVALID=1; oDIG and oERR held stable.
    - iREADY=1 with no new event: go to TRACK.
    - iREADY=1 with a new event on the same edge: load the new event and stay in PRESENT (back-to-back, no bubble).
    - iREADY=0 with a new event: drop the new event, set oOVF, and still update last-emitted.
- Tracking continues in every state. oOVF clears only on reset.

Optional Feature:
- Macro: SEG7_CAPTURE_DP_EN.
- When defined:
  - Adds port iDP (input 1, active-low decimal point) and port oDP (output 1, active-high).
  - iDP is registered and included in the stability and duplicate comparison as an 8-bit pattern.
  - oDP is loaded with the event; reset value 0.
- When undefined: neither port exists and only 7-bit patterns are compared.

Test Plan:
1. Reset, STABLE_CYCLES=4, iREADY=1, iSEG=7'b0100100 from edge 1 -> oVALID high exactly at edge 6 for one cycle, oDIG=2, oERR=0. No further event while the pattern is held.
2. iSEG=0110000 for 3 cycles, then 0011001 held -> exactly one event, oDIG=4; digit 3 is never emitted.
3. iSEG=7'b1010101 held -> one event with oERR=1, oDIG=0.
4. iREADY=0; qualify 0010010, then qualify 0000010 -> oVALID stays high with oDIG=5 and oOVF=1. Then iREADY=1 for 1 cycle -> one handshake and oVALID drops.
5. Sequence 0000000 -> 1111111 -> 0000000, each held 6 cycles -> two events with oDIG=8, and oBLANK=1 only between them. Repeating 0000000 without the blank yields one event.
6. iRST_N=0 for one cycle at count 3 of 4, then the pattern is held -> event appears a full STABLE_CYCLES+1 cycles after reset release. With SEG7_CAPTURE_DP_EN, toggling iDP alone produces a new event with the same oDIG and oDP updated.
